// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared types and constants for the cpu instruction sequencer
package cpu_seq_pkg;

   localparam int INSTR_W = 16;

   // Bit positions of the captured {N,V,Z} flag vector
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_READY,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CAPTURE,
      S_FINISH,
      S_ERROR
   } seq_state_t;

   // States in which the sequencer waits on the cpu and the timeout counter runs
   function automatic logic is_wait_state(input seq_state_t s);
      return (s == S_READY) || (s == S_WAIT_BUSY) || (s == S_WAIT_DONE);
   endfunction

endpackage

// File: rtl/seq_prog_buf.sv
// rtl/seq_prog_buf.sv - program buffer, one synchronous write port and one async read port
module seq_prog_buf
   import cpu_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues buffered instructions to the cpu one at a time and captures results
module instr_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               prog_we,
   input  logic [AW-1:0]      prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic [AW-1:0]      prog_last,
   input  logic               go,
   input  logic               abort,
   input  logic               cpu_w,
   input  logic [INSTR_W-1:0] cpu_out,
   input  logic               cpu_N,
   input  logic               cpu_V,
   input  logic               cpu_Z,
   output logic [INSTR_W-1:0] cpu_in,
   output logic               cpu_load,
   output logic               cpu_s,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [AW-1:0]      pc,
   output logic [INSTR_W-1:0] last_out,
   output logic [2:0]         last_flags
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

   seq_state_t         state;
   seq_state_t         state_next;
   logic [TW-1:0]      tmo_cnt;
   logic               tmo_hit;
   logic [AW-1:0]      last_idx;
   logic [INSTR_W-1:0] buf_word;

   seq_prog_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (prog_we && !busy),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc),
      .rdata (buf_word)
   );

   assign tmo_hit = (tmo_cnt == TMO_MAX);

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (go) state_next = S_READY;
         S_READY:     if (cpu_w) state_next = S_LOAD;
                      else if (tmo_hit) state_next = S_ERROR;
         S_LOAD:      state_next = S_START;
         S_START:     state_next = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!cpu_w) state_next = S_WAIT_DONE;
                      else if (tmo_hit) state_next = S_ERROR;
         S_WAIT_DONE: if (cpu_w) state_next = S_CAPTURE;
                      else if (tmo_hit) state_next = S_ERROR;
         S_CAPTURE:   state_next = (pc == last_idx) ? S_FINISH : S_LOAD;
         S_FINISH:    state_next = S_IDLE;
         S_ERROR:     state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
      // abort overrides everything, including a same-cycle go in IDLE
      if (abort) begin
         state_next = S_IDLE;
      end
   end

   // Strobes are suppressed while reset or abort is asserted
   always_comb begin
      cpu_load = (state == S_LOAD)  && !abort && reset;
      cpu_s    = (state == S_START) && !abort && reset;
      cpu_in   = ((state == S_LOAD) || (state == S_START)) ? buf_word : '0;
      busy     = !((state == S_IDLE) || (state == S_FINISH) || (state == S_ERROR));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         tmo_cnt    <= '0;
         last_idx   <= '0;
         pc         <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         last_out   <= '0;
         last_flags <= '0;
      end else begin
         state <= state_next;

         if (is_wait_state(state_next) && (state_next != state)) begin
            tmo_cnt <= '0;
         end else if (is_wait_state(state)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         if ((state == S_IDLE) && (state_next == S_READY)) begin
            last_idx <= prog_last;
            pc       <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
         end

         if ((state == S_CAPTURE) && !abort) begin
            last_out           <= cpu_out;
            last_flags[FLAG_N] <= cpu_N;
            last_flags[FLAG_V] <= cpu_V;
            last_flags[FLAG_Z] <= cpu_Z;
            if (state_next == S_LOAD) begin
               pc <= pc + AW'(1);
            end
         end

         if (state_next == S_FINISH) begin
            done <= 1'b1;
         end
         if (state_next == S_ERROR) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer with a small cpu model
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [15:0] prog_data;
   logic [3:0]  prog_last;
   logic        go;
   logic        abort;
   logic        cpu_w;
   logic [15:0] cpu_out;
   logic        cpu_N, cpu_V, cpu_Z;
   logic [15:0] cpu_in;
   logic        cpu_load, cpu_s, busy, done, err;
   logic [3:0]  pc;
   logic [15:0] last_out;
   logic [2:0]  last_flags;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   instr_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(64)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_last  (prog_last),
      .go         (go),
      .abort      (abort),
      .cpu_w      (cpu_w),
      .cpu_out    (cpu_out),
      .cpu_N      (cpu_N),
      .cpu_V      (cpu_V),
      .cpu_Z      (cpu_Z),
      .cpu_in     (cpu_in),
      .cpu_load   (cpu_load),
      .cpu_s      (cpu_s),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .pc         (pc),
      .last_out   (last_out),
      .last_flags (last_flags)
   );

   always #5 clk = ~clk;

   // Strobe logger
   logic [15:0] load_log[$];
   int          s_cnt   = 0;
   int          overlap = 0;

   always @(posedge clk) begin
      if (cpu_load) load_log.push_back(cpu_in);
      if (cpu_s) s_cnt++;
      if (cpu_load && cpu_s) overlap++;
   end

   // Behavioural cpu: MOV Rn,#imm8 and ADD Rd,Rn,Rm with N/V/Z
   logic [15:0] regs [8];
   logic [15:0] ir;
   int          lat   = 2;
   int          lat_cnt;
   logic        stuck = 1'b0;
   logic [16:0] sum;

   always @(posedge clk) begin
      if (!rst_n) begin
         cpu_w <= 1'b1;
      end else begin
         if (cpu_load) ir <= cpu_in;
         if (cpu_s) begin
            if (!stuck) begin
               cpu_w   <= 1'b0;
               lat_cnt <= lat;
            end
         end else if (!cpu_w) begin
            if (lat_cnt == 0) begin
               cpu_w <= 1'b1;
               if (ir[15:11] == 5'b11010) begin
                  regs[ir[10:8]] = {{8{ir[7]}}, ir[7:0]};
               end else if (ir[15:11] == 5'b10100) begin
                  sum = {1'b0, regs[ir[10:8]]} + {1'b0, regs[ir[2:0]]};
                  regs[ir[7:5]] = sum[15:0];
                  cpu_out <= sum[15:0];
                  cpu_N   <= sum[15];
                  cpu_Z   <= (sum[15:0] == 16'h0);
                  cpu_V   <= (regs[ir[10:8]][15] == regs[ir[2:0]][15]) ? 1'b0 : 1'b0;
                  if ((ir[10:8] != ir[7:5]) && (ir[2:0] != ir[7:5]))
                     cpu_V <= (regs[ir[10:8]][15] == regs[ir[2:0]][15]) &&
                              (sum[15] != regs[ir[10:8]][15]);
               end
            end else begin
               lat_cnt <= lat_cnt - 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [3:0] a, input logic [15:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic start_run(input logic [3:0] last);
      prog_last = last;
      go        = 1'b1;
      tick();
      go        = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && !err && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_s();
      int n = 0;
      while (!cpu_s && n < 200) begin
         tick();
         n++;
      end
   endtask

   int base;
   int s_base;
   int n;

   initial begin
      rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      prog_last = '0; go = 1'b0; abort = 1'b0;
      cpu_out = '0; cpu_N = 1'b0; cpu_V = 1'b0; cpu_Z = 1'b0;
      for (int i = 0; i < 8; i++) regs[i] = '0;
      tick(); tick();

      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_pc", pc, 0);
      check("rst_last_out", last_out, 0);
      check("rst_flags", last_flags, 0);
      check("rst_strobes", {cpu_load, cpu_s}, 0);
      check("rst_cpu_in", cpu_in, 0);
      rst_n = 1'b1;
      tick();

      // 1: MOV R0,#5 / MOV R1,#3 / ADD R2,R1,R0
      host_write(4'd0, 16'hD005);
      host_write(4'd1, 16'hD103);
      host_write(4'd2, 16'hA140);
      base = load_log.size(); s_base = s_cnt;
      start_run(4'd2);
      check("t1_busy", busy, 1);
      wait_done();
      check("t1_done", done, 1);
      check("t1_err", err, 0);
      check("t1_pc", pc, 2);
      check("t1_last_out", last_out, 16'd8);
      check("t1_flags", last_flags, 3'b000);
      check("t1_loads", load_log.size() - base, 3);
      check("t1_starts", s_cnt - s_base, 3);
      check("t1_word0", load_log[base], 16'hD005);
      check("t1_word1", load_log[base+1], 16'hD103);
      check("t1_word2", load_log[base+2], 16'hA140);
      tick();
      check("t1_idle_done_sticky", {busy, done}, 2'b01);

      // 2: cpu never goes busy -> timeout in WAIT_BUSY
      stuck = 1'b1;
      start_run(4'd0);
      check("t2_done_cleared", done, 0);
      wait_s();
      check("t2_saw_start", cpu_s, 1);
      n = 0;
      while (!err && n < 200) begin
         tick();
         n++;
      end
      check("t2_cycles_to_err", n, 65);
      check("t2_err", err, 1);
      check("t2_busy", busy, 0);
      check("t2_pc", pc, 0);
      tick();
      check("t2_err_sticky_idle", {busy, err}, 2'b01);
      stuck = 1'b0;

      // 3: abort during WAIT_DONE of instruction 1 of 4
      lat = 6;
      host_write(4'd0, 16'hD00A);
      host_write(4'd1, 16'hD114);
      host_write(4'd2, 16'hA140);
      host_write(4'd3, 16'hA262);
      base = load_log.size(); s_base = s_cnt;
      start_run(4'd3);
      check("t3_err_cleared", err, 0);
      wait_s();
      tick();
      wait_s();
      check("t3_second_start", s_cnt - s_base + 1, 2);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t3_busy", busy, 0);
      check("t3_done", done, 0);
      check("t3_pc", pc, 1);
      for (int i = 0; i < 20; i++) tick();
      check("t3_loads", load_log.size() - base, 2);
      check("t3_starts", s_cnt - s_base, 2);
      lat = 2;

      // 4: host write while busy is dropped
      host_write(4'd0, 16'hD480);
      host_write(4'd1, 16'hA4A4);
      base = load_log.size();
      start_run(4'd1);
      host_write(4'd0, 16'hFFFF);
      wait_done();
      check("t4_done", done, 1);
      check("t4_last_out", last_out, 16'hFF00);
      check("t4_flags", last_flags, 3'b100);
      check("t4_word0", load_log[base], 16'hD480);
      tick();
      base = load_log.size();
      start_run(4'd0);
      wait_done();
      check("t4_rerun_word0", load_log[base], 16'hD480);
      check("t4_rerun_pc", pc, 0);
      tick();

      // 5: go held across a whole run
      base = load_log.size();
      prog_last = 4'd0;
      go = 1'b1;
      tick();
      wait_done();
      check("t5_done_first", done, 1);
      check("t5_loads_first", load_log.size() - base, 1);
      tick();
      check("t5_idle", {busy, done}, 2'b01);
      tick();
      check("t5_restart", {busy, done}, 2'b10);
      go = 1'b0;
      wait_done();
      check("t5_done_second", done, 1);
      check("t5_loads_second", load_log.size() - base, 2);
      tick();

      // 6: reset during START
      start_run(4'd1);
      wait_s();
      s_base = s_cnt;
      rst_n = 1'b0;
      #1;
      check("t6_no_strobe_in_reset", {cpu_load, cpu_s}, 0);
      tick();
      check("t6_outputs_zero", {busy, done, err, pc, last_out, last_flags, cpu_load, cpu_s},
            0);
      check("t6_cpu_in", cpu_in, 0);
      rst_n = 1'b1;
      check("t6_start_not_seen", s_cnt - s_base, 0);
      tick();
      base = load_log.size();
      start_run(4'd1);
      wait_done();
      check("t6_done", done, 1);
      check("t6_pc", pc, 1);
      check("t6_word0", load_log[base], 16'hD480);
      check("t6_last_out", last_out, 16'hFF00);

      check("strobe_overlap", overlap, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Instruction-issue master for the 16-bit cpu; it drives the cpu's `in`/`load`/`s` inputs and consumes its `w`, `out` and N/V/Z outputs. It holds a small program buffer, written by a host port, and issues one instruction at a time: load, start, wait for completion. After each instruction it captures the cpu result and flags. It sits between the host/test harness and cpu on the board top level.

Parameters:
DEPTH, 16, program buffer entries (power of 2)
AW, 4, address width, log2(DEPTH)
TIMEOUT, 64, max cycles in any cpu-wait state before error (>=4)

Ports:
clk  in  1  system clock, all logic posedge
reset  in  1  synchronous, active-low reset
prog_we  in  1  host write strobe for program buffer
prog_addr  in  AW  host write address
prog_data  in  16  host write data (instruction word)
prog_last  in  AW  index of last instruction to issue; sampled on go
go  in  1  start issuing from index 0
abort  in  1  stop and return to idle
cpu_w  in  1  cpu wait/ready (1 = cpu idle in wait state)
cpu_out  in  16  cpu datapath result
cpu_N, cpu_V, cpu_Z  in  1 each  cpu status flags
cpu_in  out  16  instruction word to cpu
cpu_load  out  1  instruction-register load strobe
cpu_s  out  1  cpu start strobe
busy  out  1  sequence in progress
done  out  1  sticky, whole program completed
err  out  1  sticky, timeout occurred
pc  out  AW  index of instruction currently/last issued
last_out  out  16  cpu_out captured at end of last instruction
last_flags  out  3  {N,V,Z} captured with last_out

Behaviour:
- reset low at posedge: state IDLE. All outputs 0, including pc, last_out, last_flags, done and err. Buffer contents are not reset.
- Buffer: 1 write port and 1 combinational read port at pc. Writes with prog_we=1 are accepted only when busy=0; otherwise they are dropped.
- States: IDLE, READY, LOAD, START, WAIT_BUSY, WAIT_DONE, CAPTURE, FINISH, ERROR.
- IDLE: on go=1, latch prog_last into last_idx, set pc=0, clear done/err, go to READY. busy=1 in every state except IDLE, FINISH and ERROR.
- READY: wait for cpu_w=1, then go to LOAD.
- LOAD (1 cycle): cpu_in=buf[pc], cpu_load=1. Go to START.
- START (1 cycle): cpu_s=1, cpu_in held. Go to WAIT_BUSY.
- WAIT_BUSY: wait for cpu_w=0 (cpu accepted start), then go to WAIT_DONE.
- WAIT_DONE: wait for cpu_w=1, then go to CAPTURE.
- CAPTURE (1 cycle): last_out<=cpu_out and last_flags<={cpu_N,cpu_V,cpu_Z}.
  - If pc==last_idx, go to FINISH.
  - Otherwise pc<=pc+1 and go to LOAD; READY is skipped because cpu_w is already 1.
- FINISH: done=1. Next cycle go to IDLE; done stays 1 until the next go.
- Timeout: one counter, cleared on entry to READY, WAIT_BUSY and WAIT_DONE, incremented each cycle in those states.
  - If the counter reaches TIMEOUT-1 while still waiting, go to ERROR: err=1, pc frozen.
  - ERROR goes to IDLE the next cycle; err stays sticky until the next go.
- abort=1 in any non-IDLE state: next state is IDLE, cpu_load/cpu_s=0 that cycle, done unchanged. abort has priority over every other transition. abort in IDLE has no effect.
- go while busy: ignored.
- go and abort in the same cycle in IDLE: abort wins, remain IDLE.
- cpu_load and cpu_s are never high in the same cycle. Each is exactly one cycle wide per instruction.
- pc never wraps past last_idx. With last_idx=DEPTH-1, the final CAPTURE does not increment.
- cpu_in=0 outside LOAD/START.
- Minimum cost per instruction: 4 cycles plus cpu execution time.
- Reset mid-sequence: behaves exactly as reset from any state. No strobes in the reset cycle.

Decomposition:
- Package cpu_seq_pkg: state enum seq_state_t, instruction width constant INSTR_W=16, flag-order constants for {N,V,Z}.
- Sub-module seq_prog_buf: DEPTH x 16 buffer with one synchronous write and one async read. The FSM, timeout counter and capture registers live in the top.

Test Plan:
1. Write MOV R0,#5 / MOV R1,#3 / ADD R2,R1,R0 to indexes 0..2, prog_last=2, go, real cpu attached, cpu_w=1 -> three load/s pulse pairs in order, done=1, err=0, pc=2, last_out=8, last_flags=3'b000.
2. Behavioural cpu model holds cpu_w=1 after cpu_s (never goes busy), TIMEOUT=64 -> exactly 64 cycles in WAIT_BUSY, then err=1, busy=0, pc=0, then IDLE.
3. abort asserted during WAIT_DONE of instruction 1 of 4 -> IDLE next cycle, no further cpu_load/cpu_s, done=0, pc=1.
4. prog_we to index 0 with 16'hFFFF while busy -> buffer unchanged. Rerun shows the original word on cpu_in during LOAD.
5. go held high across an entire run, prog_last=0 -> single instruction issued. After FINISH, IDLE sees go=1 and restarts: second load pulse appears, done cleared then set again.
6. reset low for one cycle during START -> next cycle all outputs 0, state IDLE, cpu_s=0. A later go runs normally from index 0.
